// File: rtl/reg_file_param.sv
// -----------------------------------------------------------------------------
// reg_file_param
//
// Parameterised register file with one write port and two combinational read
// ports. Each register carries a "written" flag, and busy_cnt reports how many
// distinct registers have been written since the last clear.
//
// Parameters
//   WIDTH     data bits per register (>= 1)
//   DEPTH     number of registers (2..256, need not be a power of two)
//   ADDR_W    address bits, 2**ADDR_W >= DEPTH
//   ZERO_REG  1: register 0 is hardwired to zero and can never be written
//   BYPASS    1: a legal write in the current cycle is forwarded to any read
//             port addressing the same register
//
// Ports
//   clk        single clock, all state changes on the rising edge
//   clr        asynchronous active-low clear of registers, flags and busy_cnt
//   wr_en      write enable
//   wr_addr    write address
//   wr_data    write data
//   rd_addr_a  read port A address
//   rd_data_a  read port A data (combinational)
//   rd_addr_b  read port B address
//   rd_data_b  read port B data (combinational)
//   busy_cnt   number of registers written since the last clear
// -----------------------------------------------------------------------------
module reg_file_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [WIDTH-1:0]  rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_b,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] written;
  logic [DEPTH-1:0] wr_sel;
  logic             wr_in_range;
  logic             wr_zero_blk;
  logic             wr_legal;
  logic             first_write;

  // ---------------------------------------------------------------------------
  // Write qualification
  // ---------------------------------------------------------------------------
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_C);
  assign wr_zero_blk = (ZERO_REG != 0) && (wr_addr == '0);

  // clr is folded in so that the forwarding path is also silenced while the
  // file is held in clear; the storage itself is covered by the async reset.
  assign wr_legal = wr_en && wr_in_range && !wr_zero_blk && clr;

  // One-hot decode by explicit compare keeps the address width independent of
  // the array size when DEPTH is not a power of two.
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_addr == ADDR_W'(i)) begin
        wr_sel[i] = 1'b1;
      end
    end
  end

  // A write counts toward busy_cnt only the first time a register is hit.
  assign first_write = wr_legal && (|(wr_sel & ~written));

  // ---------------------------------------------------------------------------
  // Storage, written flags and occupancy counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_legal) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wr_sel[i]) begin
          regs[i] <= wr_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      written <= '0;
    end else if (wr_legal) begin
      written <= written | wr_sel;
    end
  end

  // The flag vector already bounds the count; the compare only makes the
  // ceiling explicit.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      busy_cnt <= '0;
    end else if (first_write && (busy_cnt < DEPTH_C)) begin
      busy_cnt <= busy_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  // Addresses that match no register fall through to zero, which covers the
  // out-of-range case without a separate compare.
  function automatic logic [WIDTH-1:0] lookup(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] val;
    val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) begin
        val = regs[i];
      end
    end
    if ((BYPASS != 0) && wr_legal && (addr == wr_addr)) begin
      val = wr_data;
    end
    if (!clr) begin
      val = '0;
    end
    return val;
  endfunction

  always_comb begin
    rd_data_a = lookup(rd_addr_a);
  end

  always_comb begin
    rd_data_b = lookup(rd_addr_b);
  end

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

  logic        clk = 1'b0;
  logic        clr;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  rd_addr_a;
  logic [3:0]  rd_addr_b;

  logic [31:0] a0, b0, a1, b1;
  logic [4:0]  cnt0, cnt1;

  always #5 clk = ~clk;

  // dut0: default configuration (DEPTH 16, zero register, bypass)
  reg_file_param dut0 (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(a0),
    .rd_addr_b(rd_addr_b), .rd_data_b(b0),
    .busy_cnt(cnt0)
  );

  // dut1: DEPTH 12, no zero register, no bypass
  reg_file_param #(
    .WIDTH(32), .DEPTH(12), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)
  ) dut1 (
    .clk(clk), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_data_a(a1),
    .rd_addr_b(rd_addr_b), .rd_data_b(b1),
    .busy_cnt(cnt1)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  event chk_ev;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      0:       return a0;
      1:       return b0;
      2:       return {27'b0, cnt0};
      3:       return a1;
      4:       return b1;
      5:       return {27'b0, cnt1};
      default: return 'x;
    endcase
  endfunction

  // Monitor: drains the scoreboard each time the stimulus presents a sample.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        e   = sb.pop_front();
        act = actual(e.sel);
        n_total++;
        if (act === e.exp) begin
          n_pass++;
        end else begin
          $display("FAIL %s (port %0d): got %h expected %h at %0t",
                   e.name, e.sel, act, e.exp, $time);
        end
      end
    end
  end

  task automatic push(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n;
    e.sel  = sel;
    e.exp  = v;
    sb.push_back(e);
  endtask

  task automatic ck_a(input string n, input logic [31:0] e0, input logic [31:0] e1);
    push({n, "_a0"}, 0, e0);
    push({n, "_a1"}, 3, e1);
  endtask

  task automatic ck_b(input string n, input logic [31:0] e0, input logic [31:0] e1);
    push({n, "_b0"}, 1, e0);
    push({n, "_b1"}, 4, e1);
  endtask

  task automatic ck_cnt(input string n, input logic [31:0] e0, input logic [31:0] e1);
    push({n, "_cnt0"}, 2, e0);
    push({n, "_cnt1"}, 5, e1);
  endtask

  task automatic flush();
    ->chk_ev;
    #1;
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Clear pulse of 2 ns; a pending write during clear must not forward.
    clr       = 1'b0;
    wr_en     = 1'b1;
    wr_addr   = 4'd7;
    wr_data   = 32'h0000_0077;
    rd_addr_a = 4'd7;
    rd_addr_b = 4'd0;
    #1;
    ck_a("clr_bypass", 32'h0, 32'h0);
    flush();
    wr_en = 1'b0;
    clr   = 1'b1;

    @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      rd_addr_a = 4'(i);
      rd_addr_b = 4'(15 - i);
      ck_a($sformatf("rst_%0d", i), 32'h0, 32'h0);
      ck_b($sformatf("rst_%0d", i), 32'h0, 32'h0);
      flush();
    end
    ck_cnt("rst", 0, 0);
    flush();

    // Basic write/read and rewrite
    wr(4'd3, 32'h0000_000A);
    wr(4'd5, 32'h0000_000B);
    @(negedge clk);
    rd_addr_a = 4'd3;
    rd_addr_b = 4'd5;
    ck_a("wr3", 32'h0000_000A, 32'h0000_000A);
    ck_b("wr5", 32'h0000_000B, 32'h0000_000B);
    ck_cnt("two", 2, 2);
    flush();
    wr(4'd3, 32'h0000_000C);
    ck_a("rewr3", 32'h0000_000C, 32'h0000_000C);
    ck_cnt("rewr", 2, 2);
    flush();

    // Zero register
    wr(4'd0, 32'hFFFF_FFFF);
    rd_addr_a = 4'd0;
    ck_a("r0", 32'h0, 32'hFFFF_FFFF);
    ck_cnt("r0", 2, 3);
    flush();

    // Bypass of a legal write
    @(negedge clk);
    wr_en     = 1'b1;
    wr_addr   = 4'd7;
    wr_data   = 32'h1234_5678;
    rd_addr_a = 4'd7;
    rd_addr_b = 4'd7;
    #1;
    ck_a("byp_pre", 32'h1234_5678, 32'h0);
    ck_b("byp_pre", 32'h1234_5678, 32'h0);
    flush();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    ck_a("byp_post", 32'h1234_5678, 32'h1234_5678);
    ck_cnt("byp", 3, 4);
    flush();

    // Write to r0: illegal on dut0 (no forward), legal on dut1 (no bypass)
    @(negedge clk);
    wr_en     = 1'b1;
    wr_addr   = 4'd0;
    wr_data   = 32'h0000_0055;
    rd_addr_a = 4'd0;
    #1;
    ck_a("r0byp_pre", 32'h0, 32'hFFFF_FFFF);
    flush();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    ck_a("r0byp_post", 32'h0, 32'h0000_0055);
    ck_cnt("r0byp", 3, 4);
    flush();

    // Address 13: in range for dut0, out of range for dut1
    @(negedge clk);
    wr_en     = 1'b1;
    wr_addr   = 4'd13;
    wr_data   = 32'hDEAD_BEEF;
    rd_addr_a = 4'd13;
    rd_addr_b = 4'd13;
    #1;
    ck_a("r13_pre", 32'hDEAD_BEEF, 32'h0);
    flush();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    ck_a("r13_post", 32'hDEAD_BEEF, 32'h0);
    ck_b("r13_post", 32'hDEAD_BEEF, 32'h0);
    ck_cnt("r13", 4, 4);
    flush();

    // dut1 boundary: 11 is its last register, 12 the first illegal one
    wr(4'd11, 32'h0000_0011);
    wr(4'd12, 32'h0000_0012);
    rd_addr_a = 4'd11;
    rd_addr_b = 4'd12;
    ck_a("r11", 32'h0000_0011, 32'h0000_0011);
    ck_b("r12", 32'h0000_0012, 32'h0);
    ck_cnt("edge", 6, 5);
    flush();

    // wr_en low: nothing changes across an edge
    @(negedge clk);
    wr_addr = 4'd11;
    wr_data = 32'h0000_FFFF;
    @(posedge clk);
    #1;
    ck_a("hold", 32'h0000_0011, 32'h0000_0011);
    ck_cnt("hold", 6, 5);
    flush();

    // Fill r1..r15: counts saturate at DEPTH-1 (dut0) and DEPTH (dut1)
    for (int i = 1; i < 16; i++) begin
      wr(4'(i), 32'h0000_0100 + 32'(i));
    end
    rd_addr_a = 4'd15;
    rd_addr_b = 4'd9;
    ck_a("fill15", 32'h0000_010F, 32'h0);
    ck_b("fill9", 32'h0000_0109, 32'h0000_0109);
    ck_cnt("full", 15, 12);
    flush();

    // Async clear between edges with a write pending
    @(negedge clk);
    wr_en     = 1'b1;
    wr_addr   = 4'd4;
    wr_data   = 32'h0000_ABCD;
    rd_addr_a = 4'd4;
    rd_addr_b = 4'd9;
    #1;
    ck_a("pre_clr", 32'h0000_ABCD, 32'h0000_0104);
    flush();
    clr = 1'b0;
    #1;
    ck_a("in_clr", 32'h0, 32'h0);
    ck_b("in_clr", 32'h0, 32'h0);
    ck_cnt("in_clr", 0, 0);
    flush();
    @(posedge clk);
    #1;
    ck_a("clr_edge", 32'h0, 32'h0);
    ck_cnt("clr_edge", 0, 0);
    flush();
    @(negedge clk);
    clr = 1'b1;
    #1;
    ck_a("rel_pre", 32'h0000_ABCD, 32'h0);
    flush();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    ck_a("rel_post", 32'h0000_ABCD, 32'h0000_ABCD);
    ck_b("rel_post", 32'h0, 32'h0);
    ck_cnt("rel", 1, 1);
    flush();

    flush();
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
